mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 47 ++++
 rtl/mem_load_align.sv | 32 +++
 rtl/mem_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage.
//   - access-size encodings carried on exe_mem_size
//   - FSM state encoding of the stage (also exported on the debug port)
//   - default register write-address width
//   - helpers that derive misalignment, store byte strobes and store lanes
package mem_stage_pkg;

    localparam int WADDR_W_DEFAULT = 6;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;  // 2'd3 is treated as a word as well

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // A byte is always aligned; a half needs addr[0]=0; a word needs addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr[0];
            default:   is_misaligned = (addr != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SIZE_BYTE: store_strb = 4'b0001 << addr;
            SIZE_HALF: store_strb = 4'b0011 << addr;
            default:   store_strb = 4'b1111;
        endcase
    endfunction

    // The source value is replicated across every lane so the strobes alone
    // select which bytes the memory actually writes.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: store_lanes = {4{data[7:0]}};
            SIZE_HALF: store_lanes = {2{data[15:0]}};
            default:   store_lanes = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/half/word out of a 32-bit
// read beat and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata        in  32  raw read data from memory
//   addr         in  2   low address bits of the access
//   size         in  2   access size (byte/half/word, 3 = word)
//   mem_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result       out 32  aligned, extended load value
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        mem_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr, 3'b000};

    always_comb begin
        case (size)
            SIZE_BYTE: result = {{24{~mem_unsigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = {{16{~mem_unsigned & shifted[15]}}, shifted[15:0]};
            SIZE_WORD: result = shifted;
            default:   result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction from the execute stage,
// issues at most one data-memory request for it, waits for the response,
// aligns load data and hands the result to writeback.
//
// Handshakes: a transfer on a valid/ready pair happens on the rising clk
// edge where both are 1 in the preceding cycle (exe_valid/mem_allowin,
// wb_valid/wb_allowin, data_req/data_addr_ok). data_data_ok is a one-cycle
// response strobe that is only honoured while waiting for a response.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   exe_valid / mem_allowin     upstream handshake
//   exe_reg_en, exe_reg_waddr   regfile write enable / destination
//   exe_mem_read, exe_mem_write load / store flags
//   exe_mem_size, exe_mem_unsigned  access size, zero-extend loads
//   exe_alu_result, exe_store_data  address (or ALU value), store source
//   data_req, data_wr, data_wstrb, data_addr, data_wdata  memory request
//   data_addr_ok, data_data_ok, data_rdata               memory response
//   wb_allowin / wb_valid       downstream handshake
//   wb_reg_en, wb_reg_waddr, wb_mem_read, wb_alu_result, wb_mem_rdata
//   mem_adel, mem_ades          misaligned load / store, qualified by wb_valid
//   dbg_state                   current FSM state (state_t encoding)
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WADDR_W = WADDR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               exe_valid,
    output logic               mem_allowin,
    input  logic               exe_reg_en,
    input  logic [WADDR_W-1:0] exe_reg_waddr,
    input  logic               exe_mem_read,
    input  logic               exe_mem_write,
    input  logic [1:0]         exe_mem_size,
    input  logic               exe_mem_unsigned,
    input  logic [31:0]        exe_alu_result,
    input  logic [31:0]        exe_store_data,

    output logic               data_req,
    output logic               data_wr,
    output logic [3:0]         data_wstrb,
    output logic [31:0]        data_addr,
    output logic [31:0]        data_wdata,
    input  logic               data_addr_ok,
    input  logic               data_data_ok,
    input  logic [31:0]        data_rdata,

    input  logic               wb_allowin,
    output logic               wb_valid,
    output logic               wb_reg_en,
    output logic [WADDR_W-1:0] wb_reg_waddr,
    output logic               wb_mem_read,
    output logic [31:0]        wb_alu_result,
    output logic [31:0]        wb_mem_rdata,
    output logic               mem_adel,
    output logic               mem_ades,

    output logic [1:0]         dbg_state
);

    state_t state_q, state_d;

    logic               stage_valid;
    logic               s_reg_en;
    logic [WADDR_W-1:0] s_waddr;
    logic               s_mem_read;
    logic               s_mem_write;
    logic [1:0]         s_size;
    logic               s_unsigned;
    logic [31:0]        s_alu;
    logic [31:0]        s_store;
    logic               s_mis;
    logic [31:0]        rdata_q;
    logic [31:0]        load_val;

    logic ready_go;
    logic accept;
    logic capture;
    logic exe_is_mem;
    logic exe_mis;

    assign exe_is_mem = exe_mem_read | exe_mem_write;
    assign exe_mis    = exe_is_mem & is_misaligned(exe_mem_size, exe_alu_result[1:0]);

    // ready_go is combinational on data_data_ok so a finishing access can be
    // released and replaced in the same cycle.
    assign mem_allowin = !stage_valid || (ready_go && wb_allowin);
    assign accept      = exe_valid && mem_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_req = 1'b0;
        ready_go = 1'b0;
        case (state_q)
            ST_REQ: begin
                data_req = 1'b1;
                if (data_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    ready_go = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                ready_go = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
        // A newly accepted aligned memory op always starts with a request.
        if (accept) begin
            state_d = (exe_is_mem && !exe_mis) ? ST_REQ : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stage_valid <= 1'b0;
            s_reg_en    <= 1'b0;
            s_waddr     <= '0;
            s_mem_read  <= 1'b0;
            s_mem_write <= 1'b0;
            s_size      <= SIZE_BYTE;
            s_unsigned  <= 1'b0;
            s_alu       <= '0;
            s_store     <= '0;
            s_mis       <= 1'b0;
        end else if (accept) begin
            stage_valid <= 1'b1;
            s_reg_en    <= exe_reg_en;
            s_waddr     <= exe_reg_waddr;
            s_mem_read  <= exe_mem_read;
            s_mem_write <= exe_mem_write;
            s_size      <= exe_mem_size;
            s_unsigned  <= exe_mem_unsigned;
            s_alu       <= exe_alu_result;
            s_store     <= exe_store_data;
            s_mis       <= exe_mis;
        end else if (stage_valid && ready_go && wb_allowin) begin
            stage_valid <= 1'b0;
        end
    end

    mem_load_align u_load_align (
        .rdata        (data_rdata),
        .addr         (s_alu[1:0]),
        .size         (s_size),
        .mem_unsigned (s_unsigned),
        .result       (load_val)
    );

    // Read data is only meaningful on the response beat of a load.
    assign capture = (state_q == ST_WAIT) && data_data_ok && s_mem_read;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= load_val;
        end
    end

    assign data_wr    = s_mem_write;
    assign data_addr  = s_alu;
    assign data_wstrb = store_strb(s_size, s_alu[1:0]);
    assign data_wdata = store_lanes(s_size, s_store);

    assign wb_valid      = stage_valid && ready_go;
    assign wb_reg_en     = s_reg_en && wb_valid && !s_mis;
    assign wb_reg_waddr  = s_waddr;
    assign wb_mem_read   = s_mem_read;
    assign wb_alu_result = s_alu;
    // Forward the aligned beat directly on the response cycle; afterwards the
    // captured copy (same value) keeps the output stable.
    assign wb_mem_rdata  = capture ? load_val : rdata_q;
    assign mem_adel      = wb_valid && s_mis && s_mem_read;
    assign mem_ades      = wb_valid && s_mis && s_mem_write;

    assign dbg_state = state_q;

endmodule
